// File: rtl/ray_sphere_intersect.sv
// Ray/sphere hit test: one shared signed multiplier, twelve multiply steps per ray,
// results tagged with a raster pixel index that wraps at image_width*image_height.
module ray_sphere_intersect #(
  parameter  int DIR_W = 16,
  localparam int ACC_W = 2*DIR_W+2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DIR_W-1:0] ray_dir_x,
  input  logic signed [DIR_W-1:0] ray_dir_y,
  input  logic signed [DIR_W-1:0] ray_dir_z,
  input  logic [7:0]              camera_pos_x,
  input  logic [7:0]              camera_pos_y,
  input  logic [7:0]              camera_pos_z,
  input  logic [7:0]              sphere_cx,
  input  logic [7:0]              sphere_cy,
  input  logic [7:0]              sphere_cz,
  input  logic [7:0]              sphere_r,
  input  logic [12:0]             image_width,
  input  logic [12:0]             image_height,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    hit,
  output logic [31:0]             pixel_index,
  output logic                    out_last
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid may not depend on ready, and a raised out_valid holds its data until accepted.

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  logic [1:0]                state;
  logic [3:0]                step;
  logic signed [DIR_W-1:0]   dx, dy, dz;
  logic signed [8:0]         ocx, ocy, ocz;
  logic [7:0]                rad;
  logic signed [ACC_W-1:0]   acc_a, acc_b, acc_c;
  logic signed [2*ACC_W-1:0] p_sq, q_ac;
  logic [31:0]               counter;
  logic [31:0]               tag_index;
  logic                      tag_last;

  logic                      accept;
  logic [25:0]               area;
  logic [31:0]               last_index;
  logic                      is_last;
  logic signed [ACC_W-1:0]   op_x, op_y;
  logic signed [2*ACC_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_lo;
  logic signed [2*ACC_W:0]   disc;
  logic                      hit_next;

  assign accept = in_valid && in_ready;

  // An empty frame behaves as a one-pixel frame, so last_index is then 0.
  assign area       = 26'(image_width) * 26'(image_height);
  assign last_index = (area == 26'd0) ? 32'd0 : (32'(area) - 32'd1);
  assign is_last    = (counter == last_index);

  always_comb begin
    op_x = '0;
    op_y = '0;
    case (step)
      4'd0:    begin op_x = ACC_W'(dx);  op_y = ACC_W'(dx);  end
      4'd1:    begin op_x = ACC_W'(dy);  op_y = ACC_W'(dy);  end
      4'd2:    begin op_x = ACC_W'(dz);  op_y = ACC_W'(dz);  end
      4'd3:    begin op_x = ACC_W'(dx);  op_y = ACC_W'(ocx); end
      4'd4:    begin op_x = ACC_W'(dy);  op_y = ACC_W'(ocy); end
      4'd5:    begin op_x = ACC_W'(dz);  op_y = ACC_W'(ocz); end
      4'd6:    begin op_x = ACC_W'(ocx); op_y = ACC_W'(ocx); end
      4'd7:    begin op_x = ACC_W'(ocy); op_y = ACC_W'(ocy); end
      4'd8:    begin op_x = ACC_W'(ocz); op_y = ACC_W'(ocz); end
      4'd9:    begin op_x = ACC_W'({1'b0, rad}); op_y = ACC_W'({1'b0, rad}); end
      4'd10:   begin op_x = acc_b; op_y = acc_b; end
      4'd11:   begin op_x = acc_a; op_y = acc_c; end
      default: begin op_x = '0; op_y = '0; end
    endcase
  end

  assign prod    = op_x * op_y;
  assign prod_lo = prod[ACC_W-1:0];

  // One extra bit keeps b*b - a*c exact for every representable operand.
  assign disc     = {p_sq[2*ACC_W-1], p_sq} - {q_ac[2*ACC_W-1], q_ac};
  assign hit_next = !disc[2*ACC_W] && (acc_b[ACC_W-1] || acc_c[ACC_W-1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      step        <= '0;
      dx          <= '0;
      dy          <= '0;
      dz          <= '0;
      ocx         <= '0;
      ocy         <= '0;
      ocz         <= '0;
      rad         <= '0;
      acc_a       <= '0;
      acc_b       <= '0;
      acc_c       <= '0;
      p_sq        <= '0;
      q_ac        <= '0;
      counter     <= '0;
      tag_index   <= '0;
      tag_last    <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      hit         <= 1'b0;
      pixel_index <= '0;
      out_last    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            dx        <= ray_dir_x;
            dy        <= ray_dir_y;
            dz        <= ray_dir_z;
            ocx       <= $signed({1'b0, camera_pos_x}) - $signed({1'b0, sphere_cx});
            ocy       <= $signed({1'b0, camera_pos_y}) - $signed({1'b0, sphere_cy});
            ocz       <= $signed({1'b0, camera_pos_z}) - $signed({1'b0, sphere_cz});
            rad       <= sphere_r;
            acc_a     <= '0;
            acc_b     <= '0;
            acc_c     <= '0;
            tag_index <= counter;
            tag_last  <= is_last;
            counter   <= is_last ? 32'd0 : counter + 32'd1;
            step      <= '0;
            in_ready  <= 1'b0;
            state     <= S_CALC;
          end else begin
            in_ready  <= 1'b1;
          end
        end
        S_CALC: begin
          case (step)
            4'd0, 4'd1, 4'd2: acc_a <= acc_a + prod_lo;
            4'd3, 4'd4, 4'd5: acc_b <= acc_b + prod_lo;
            4'd6, 4'd7, 4'd8: acc_c <= acc_c + prod_lo;
            4'd9:             acc_c <= acc_c - prod_lo;
            4'd10:            p_sq  <= prod;
            default:          q_ac  <= prod;
          endcase
          if (step == 4'd11) state <= S_DECIDE;
          step <= step + 4'd1;
        end
        S_DECIDE: begin
          hit         <= hit_next;
          pixel_index <= tag_index;
          out_last    <= tag_last;
          out_valid   <= 1'b1;
          state       <= S_OUT;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
